asm_intlv_ram: RTL and testbench

Data buffer stage of the ASM interleaver, directly downstream of the enable/offset generator. Writes one frame of encoder output into a single-port-per-direction bit RAM at the generator's linear write address, then reads it back in permuted order when the modulator side requests. The permuted read address comes from an external permutation ROM addressed at `id_offset + enable`. The block tracks frame fill/drain and produces an aligned `dout`/`dout_vld` stream.

---
 rtl/asm_intlv_ram_if.sv | 30 +++
 rtl/asm_intlv_ram.sv | 99 +++++++++
 tb/tb_asm_intlv_ram.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/asm_intlv_ram_if.sv
// Bus between the ASM interleaver data buffer, its generator/modulator side
// and the permutation ROM.
interface asm_intlv_ram_if #(
   parameter int DATA_W = 1
);
   logic              din_vld;
   logic [DATA_W-1:0] din;
   logic              wen;
   logic [15:0]       enable;
   logic [15:0]       id_offset;
   logic [12:0]       m_len;
   logic              request;
   logic [15:0]       perm_addr;
   logic              perm_rd;
   logic [15:0]       perm_data;
   logic [DATA_W-1:0] dout;
   logic              dout_vld;
   logic              full;
   logic              done;
   logic              err;

   modport master (
      output din_vld, din, wen, enable, id_offset, m_len, request, perm_data,
      input  perm_addr, perm_rd, dout, dout_vld, full, done, err
   );
   modport slave (
      input  din_vld, din, wen, enable, id_offset, m_len, request, perm_data,
      output perm_addr, perm_rd, dout, dout_vld, full, done, err
   );
endinterface

// File: rtl/asm_intlv_ram.sv
// ASM interleaver frame buffer: linear fill, permuted drain through an external ROM.
// Define ASM_PERM_CHK_EN to range-check ROM outputs against the latched frame length.
module asm_intlv_ram #(
   parameter int DATA_W = 1,
   parameter int AW     = 11
) (
   input  logic              clk,
   input  logic              n_rst,
   asm_intlv_ram_if.slave    bus
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FILL  = 2'd1;
   localparam logic [1:0] READY = 2'd2;
   localparam logic [1:0] DRAIN = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [12:0]       m_len_q, wr_cnt_q, rd_cnt_q;
   logic [DATA_W-1:0] din_q, dout_q;
   logic              full_q, done_q, err_q, last_q;
   logic [1:0]        vld_pipe_q;
   logic [DATA_W-1:0] mem [2**AW];

   logic        filling, wr_ok, rd_ok, wr_last, rd_last, perm_bad, chk;
   logic [12:0] len_eff, wr_base;
   logic        unused_ok;

   assign filling = (state_q == IDLE) || (state_q == FILL);
   assign wr_ok   = bus.wen && filling;
   assign rd_ok   = bus.request && !filling;
   // On the first write the frame length is not latched yet, so use the live input.
   assign len_eff = (state_q == IDLE) ? bus.m_len : m_len_q;
   assign wr_base = (state_q == IDLE) ? 13'd0 : wr_cnt_q;
   assign wr_last = wr_ok && (wr_base + 13'd1 == len_eff);
   assign rd_last = rd_ok && (rd_cnt_q + 13'd1 == m_len_q);

`ifdef ASM_PERM_CHK_EN
   assign perm_bad = (bus.perm_data >= {3'b000, m_len_q});
`else
   assign perm_bad = 1'b0;
`endif
   assign chk       = vld_pipe_q[0] && perm_bad;
   assign unused_ok = ^bus.perm_data[15:AW];

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (wr_ok)   state_d = wr_last ? READY : FILL;
         FILL:    if (wr_last) state_d = READY;
         READY:   if (rd_ok)   state_d = rd_last ? IDLE : DRAIN;
         default: if (rd_last) state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q    <= IDLE;
         m_len_q    <= '0;
         wr_cnt_q   <= '0;
         rd_cnt_q   <= '0;
         din_q      <= '0;
         dout_q     <= '0;
         full_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         last_q     <= 1'b0;
         vld_pipe_q <= '0;
      end else begin
         state_q <= state_d;
         if (bus.din_vld) din_q <= bus.din;
         if (wr_ok) begin
            wr_cnt_q <= wr_base + 13'd1;
            if (state_q == IDLE) m_len_q <= bus.m_len;
         end
         if (wr_last) begin
            full_q   <= 1'b1;
            rd_cnt_q <= '0;
         end
         if (rd_ok)   rd_cnt_q <= rd_cnt_q + 13'd1;
         if (rd_last) full_q   <= 1'b0;
         vld_pipe_q <= {vld_pipe_q[0], rd_ok};
         last_q     <= rd_last;
         done_q     <= vld_pipe_q[0] && last_q;
         if ((bus.request && filling) || (bus.wen && !filling) || chk) err_q <= 1'b1;
         if (vld_pipe_q[0]) dout_q <= chk ? '0 : mem[bus.perm_data[AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[bus.enable[AW-1:0]] <= din_q;
   end

   assign bus.perm_rd   = rd_ok;
   assign bus.perm_addr = bus.id_offset + bus.enable;
   assign bus.dout      = dout_q;
   assign bus.dout_vld  = vld_pipe_q[1];
   assign bus.full      = full_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_asm_intlv_ram.sv
// Scoreboard bench for asm_intlv_ram: random symbols, frame-level reference model.
module tb_asm_intlv_ram;
   localparam int DW = 1;
   localparam int AW = 11;

   typedef struct {
      logic [DW-1:0] d;
      bit            last;
      bit            bad;
      int            cyc;
   } exp_t;

   logic clk = 1'b0;
   logic n_rst;
   always #5 clk = ~clk;

   asm_intlv_ram_if #(.DATA_W(DW)) bus ();
   asm_intlv_ram #(.DATA_W(DW), .AW(AW)) dut (.clk(clk), .n_rst(n_rst), .bus(bus));

   logic [15:0]   rom [65536];
   logic [DW-1:0] mem_m [2**AW];
   exp_t          sb[$];
   int            phase, len_m, wc_m, rd_m, cyc;
   bit            err_m;
   logic [DW-1:0] dq_m;
   logic [15:0]   pa, pv;
   exp_t          e;
   int            total = 0, bad = 0;
   bit            perr_seen, end_chk;

   // External permutation ROM: one cycle latency
   always @(posedge clk) if (bus.perm_rd) bus.perm_data <= rom[bus.perm_addr];

   // Frame-level model: a frame is filled with m_len writes, then drained with m_len reads
   always @(posedge clk) begin
      if (!n_rst) begin
         phase = 0; err_m = 0; dq_m = '0;
      end else begin
         int ph;
         ph = phase;
         if (bus.request) begin
            if (ph == 2) begin
               pa = bus.id_offset + bus.enable;
               pv = rom[pa];
               e.d = mem_m[pv % (2**AW)];
               e.bad = 0;
`ifdef ASM_PERM_CHK_EN
               if (int'(pv) >= len_m) begin e.d = '0; e.bad = 1; end
`endif
               rd_m++;
               e.last = (rd_m == len_m);
               e.cyc = cyc;
               sb.push_back(e);
               if (e.last) phase = 0;
            end else err_m = 1;
         end
         if (bus.wen) begin
            if (ph < 2) begin
               if (ph == 0) begin len_m = int'(bus.m_len); wc_m = 0; phase = 1; end
               mem_m[bus.enable % (2**AW)] = dq_m;
               wc_m++;
               if (wc_m == len_m) begin phase = 2; rd_m = 0; end
            end else err_m = 1;
         end
         if (bus.din_vld) dq_m = bus.din;
      end
      cyc++;
   end

   task automatic chk(input string nm, input longint act, input longint req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   always @(negedge clk) begin
      exp_t x;
      if (end_chk) chk("sb_empty", sb.size(), 0);
      else if (!n_rst) begin
         perr_seen = 0;
         chk("rst_dout", bus.dout, 0);
         chk("rst_dout_vld", bus.dout_vld, 0);
         chk("rst_full", bus.full, 0);
         chk("rst_done", bus.done, 0);
         chk("rst_err", bus.err, 0);
         chk("rst_perm_rd", bus.perm_rd, 0);
         chk("rst_perm_addr", bus.perm_addr, 0);
      end else begin
         if (bus.dout_vld) begin
            if (sb.size() == 0) chk("unexpected_dout_vld", 1, 0);
            else begin
               x = sb.pop_front();
               if (x.bad) perr_seen = 1;
               chk("dout", bus.dout, x.d);
               chk("done", bus.done, x.last);
               chk("latency", cyc - x.cyc, 2);
            end
         end else chk("done_stray", bus.done, 0);
         chk("full", bus.full, phase == 2);
         chk("err", bus.err, err_m | perr_seen);
      end
   end

   task automatic step;
      @(posedge clk); #1;
   endtask

   task automatic idle_in;
      bus.din_vld = 0; bus.din = '0; bus.wen = 0; bus.enable = 0;
      bus.id_offset = 0; bus.m_len = 0; bus.request = 0;
   endtask

   task automatic do_reset;
      n_rst = 0;
      idle_in();
      sb.delete();
      repeat (2) step();
      n_rst = 1;
      step();
   endtask

   task automatic fill(input int n, input int len, input int preq);
      for (int k = 0; k <= n; k++) begin
         bus.din_vld   = (k < n);
         bus.din       = DW'($urandom);
         bus.wen       = (k > 0);
         bus.enable    = 16'(k - 1);
         bus.m_len     = (k <= 1) ? 13'(len) : 13'($urandom);
         bus.request   = (k == preq);
         bus.id_offset = 16'($urandom);
         step();
      end
      idle_in();
   endtask

   task automatic drain(input int n, input int id, input int wen_at, input int rst_at);
      for (int r = 0; r < n; r++) begin
         if (r == rst_at) begin do_reset(); return; end
         if ($urandom_range(0, 3) == 0) step();
         bus.request   = 1;
         bus.enable    = 16'(r);
         bus.id_offset = 16'(id);
         bus.wen       = (r == wen_at);
         bus.din       = DW'($urandom);
         step();
         bus.request = 0;
         bus.wen     = 0;
      end
      repeat (4) step();
   endtask

   initial begin
      end_chk = 0; perr_seen = 0; cyc = 0; phase = 0; err_m = 0;
      for (int i = 0; i < 65536; i++) rom[i] = 16'(i);
      n_rst = 0;
      idle_in();
      repeat (3) step();
      n_rst = 1;
      step();
      // Identity ROM at link-5 base
      for (int k = 0; k < 288; k++) rom[16'h03c0 + k] = 16'(k);
      fill(288, 'h120, -1);
      drain(288, 'h03c0, -1, -1);
      // Reversing permutation, premature request during fill, write during drain
      for (int i = 0; i < 952; i++) rom[i] = 16'(951 - i);
      fill(952, 'h3b8, 10);
      drain(952, 0, 5, -1);
      // Reset mid-drain, then a fresh frame with one out-of-range ROM entry
      fill(672, 'h2a0, -1);
      drain(672, 0, -1, 100);
      rom[16'h03c0 + 7] = 16'h0200;
      fill(288, 'h120, -1);
      drain(288, 'h03c0, -1, -1);
      end_chk = 1;
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
